// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle: master drives operands and consumes results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_fa.sv
// One-bit half and full adder cells used in the serial adder's ripple slice.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b;
    assign o_cout = i_a & i_b;
endmodule

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_sum(w_s0),  .o_cout(w_c0));
    half_adder u_ha1 (.i_a(w_s0), .i_b(i_cin), .o_sum(o_sum), .o_cout(w_c1));

    assign o_cout = w_c0 | w_c1;
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE-wide ripple slice applied LSB first,
// WIDTH/BITS_PER_CYCLE clocks per operation, valid/ready on both sides.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [BPC:0]     w_c;
    logic [BPC-1:0]   w_s;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_accept;
    logic             w_last;

    assign w_c[0] = r_carry;

    for (genvar g = 0; g < BPC; g++) begin : g_fa
        full_adder u_fa (
            .i_a   (r_a[g]),
            .i_b   (r_b[g]),
            .i_cin (w_c[g]),
            .o_sum (w_s[g]),
            .o_cout(w_c[g+1])
        );
    end

    // Slice results enter at the top so the LSB slice ends up at bit 0 after STEPS shifts.
    assign w_acc_next = (r_acc >> BPC) | (WIDTH'(w_s) << (WIDTH - BPC));
    assign w_accept   = (r_state == ST_IDLE) && bus.in_valid;
    assign w_last     = (r_state == ST_RUN) && (r_cnt == LAST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)     w_next = ST_RUN;
            ST_RUN:  if (r_cnt == LAST_STEP) w_next = ST_DONE;
            ST_DONE: if (bus.out_ready)    w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> BPC;
            r_b     <= r_b >> BPC;
            r_acc   <= w_acc_next;
            r_carry <= w_c[BPC];
            r_cnt   <= r_cnt + 1'b1;
            // Visible results move only on the final slice; the MSB carries give ovf.
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_c[BPC];
                r_ovf  <= w_c[BPC-1] ^ w_c[BPC];
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: two instances (1 and 4 bits per clock) against an arithmetic model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus1 ();
    serial_adder_if #(.WIDTH(8)) bus4 ();

    logic       d_valid, d_ready, d_cin, d_sub;
    logic [7:0] d_a, d_b;
    int         cur;

    assign bus1.in_valid  = d_valid && (cur == 0);
    assign bus4.in_valid  = d_valid && (cur == 1);
    assign bus1.out_ready = d_ready && (cur == 0);
    assign bus4.out_ready = d_ready && (cur == 1);
    assign bus1.a = d_a;  assign bus4.a = d_a;
    assign bus1.b = d_b;  assign bus4.b = d_b;
    assign bus1.cin = d_cin;  assign bus4.cin = d_cin;
    assign bus1.sub = d_sub;  assign bus4.sub = d_sub;

    logic       o_in_ready, o_out_valid, o_cout, o_ovf;
    logic [7:0] o_sum;
    assign o_in_ready  = (cur == 0) ? bus1.in_ready  : bus4.in_ready;
    assign o_out_valid = (cur == 0) ? bus1.out_valid : bus4.out_valid;
    assign o_sum       = (cur == 0) ? bus1.sum       : bus4.sum;
    assign o_cout      = (cur == 0) ? bus1.cout      : bus4.cout;
    assign o_ovf       = (cur == 0) ? bus1.ovf       : bus4.ovf;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int n_cmp = 0;
    int n_err = 0;

    // Plain integer arithmetic: unsigned result for sum/cout, signed result for overflow.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                         output logic [7:0] s, output logic co, output logic ov);
        int ua, ub, sa, sb, ru, rs;
        ua = a;  ub = b;
        sa = $signed(a);  sb = $signed(b);
        if (sub) begin
            ru = ua - ub;
            rs = sa - sb;
            co = (ua >= ub);
        end else begin
            ru = ua + ub + int'(cin);
            rs = sa + sb + int'(cin);
            co = (ru > 255);
        end
        s  = 8'(ru);
        ov = (rs > 127) || (rs < -128);
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub,
                         output logic [7:0] s, output logic co, output logic ov, output int lat);
        int w;
        cur = sel;  d_a = a;  d_b = b;  d_cin = cin;  d_sub = sub;  d_valid = 1'b1;
        w = 0;
        while (!o_in_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk);
        d_valid = 1'b0;
        lat = 0;
        while (!o_out_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        if (lat >= 50 || w >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: got no handshake within budget, required one (sel=%0d)", sel);
        end
        s = o_sum;  co = o_cout;  ov = o_ovf;
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus1.in_ready, bus1.out_valid, bus1.sum, bus1.cout, bus1.ovf} !== 12'b1_0_00000000_0_0) begin
            n_err++;
            $display("FAIL reset_bpc1: got rdy=%b vld=%b sum=%h c=%b o=%b, required 1 0 00 0 0",
                     bus1.in_ready, bus1.out_valid, bus1.sum, bus1.cout, bus1.ovf);
        end
        n_cmp++;
        if ({bus4.in_ready, bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf} !== 12'b1_0_00000000_0_0) begin
            n_err++;
            $display("FAIL reset_bpc4: got rdy=%b vld=%b sum=%h c=%b o=%b, required 1 0 00 0 0",
                     bus4.in_ready, bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf);
        end
    endtask

    typedef struct {
        int         sel;
        logic [7:0] a, b;
        logic       cin, sub;
        logic [7:0] es;
        logic       ec, eo;
        int         elat;
    } vec_t;

    task automatic test_directed();
        vec_t v[7];
        logic [7:0] s; logic co, ov; int lat;
        v[0] = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8};
        v[1] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8};
        v[2] = '{0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8};
        v[3] = '{0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 8};
        v[4] = '{0, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 8};
        v[5] = '{1, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 2};
        v[6] = '{1, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 2};
        foreach (v[i]) begin
            do_op(v[i].sel, v[i].a, v[i].b, v[i].cin, v[i].sub, s, co, ov, lat);
            n_cmp++;
            if ({s, co, ov} !== {v[i].es, v[i].ec, v[i].eo}) begin
                n_err++;
                $display("FAIL directed[%0d]: got sum=%h c=%b o=%b, required sum=%h c=%b o=%b",
                         i, s, co, ov, v[i].es, v[i].ec, v[i].eo);
            end
            n_cmp++;
            if (lat !== v[i].elat) begin
                n_err++;
                $display("FAIL latency[%0d]: got %0d, required %0d", i, lat, v[i].elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] es; logic ec, eo;
        int w;
        cur = 0;  d_a = 8'h80;  d_b = 8'h01;  d_cin = 1'b1;  d_sub = 1'b1;
        model(d_a, d_b, d_cin, d_sub, es, ec, eo);
        d_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_valid = 1'b0;
        w = 0;
        while (!o_out_valid && w < 50) begin @(negedge clk); w++; end
        for (int i = 0; i < 5; i++) begin
            d_valid = (i % 2 == 0);
            d_a = 8'($urandom);  d_b = 8'($urandom);  d_sub = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({o_out_valid, o_in_ready, o_sum, o_cout, o_ovf} !== {1'b1, 1'b0, es, ec, eo}) begin
                n_err++;
                $display("FAIL backpressure[%0d]: got vld=%b rdy=%b sum=%h c=%b o=%b, required 1 0 %h %b %b",
                         i, o_out_valid, o_in_ready, o_sum, o_cout, o_ovf, es, ec, eo);
            end
        end
        d_valid = 1'b0;
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        n_cmp++;
        if ({o_out_valid, o_in_ready, o_sum} !== {1'b0, 1'b1, es}) begin
            n_err++;
            $display("FAIL retire: got vld=%b rdy=%b sum=%h, required 0 1 %h", o_out_valid, o_in_ready, o_sum, es);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({o_out_valid, o_in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL nothing_accepted: got vld=%b rdy=%b, required 0 1", o_out_valid, o_in_ready);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] s; logic co, ov; int lat;
        cur = 0;  d_a = 8'hFF;  d_b = 8'hFF;  d_cin = 1'b1;  d_sub = 1'b0;  d_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus1.out_valid, bus1.in_ready, bus1.sum, bus1.cout, bus1.ovf} !== 12'b0_1_00000000_0_0) begin
            n_err++;
            $display("FAIL reset_midrun: got vld=%b rdy=%b sum=%h c=%b o=%b, required 0 1 00 0 0",
                     bus1.out_valid, bus1.in_ready, bus1.sum, bus1.cout, bus1.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus1.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL discarded: got out_valid=%b, required 0", bus1.out_valid);
        end
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, s, co, ov, lat);
        n_cmp++;
        if ({s, co, ov} !== {8'h46, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL after_reset: got sum=%h c=%b o=%b, required 46 0 0", s, co, ov);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        logic [7:0] es; logic ec, eo;
        cur = 0;  d_a = 8'($urandom);  d_b = 8'($urandom);  d_cin = 1'b1;  d_sub = 1'b0;
        model(d_a, d_b, d_cin, d_sub, es, ec, eo);
        d_valid = 1'b1;  d_ready = 1'b1;
        for (int c = 0; c < 45; c++) begin
            if (o_in_ready) acc.push_back(c);
            if (o_out_valid) begin
                n_cmp++;
                if ({o_sum, o_cout, o_ovf} !== {es, ec, eo}) begin
                    n_err++;
                    $display("FAIL b2b_result: got %h %b %b, required %h %b %b", o_sum, o_cout, o_ovf, es, ec, eo);
                end
            end
            @(negedge clk);
        end
        d_valid = 1'b0;
        repeat (12) @(negedge clk);
        d_ready = 1'b0;
        n_cmp++;
        if (acc.size() < 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d accepts, required at least 4", acc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (acc[i] - acc[i-1] !== 10) begin
                    n_err++;
                    $display("FAIL b2b_period[%0d]: got %0d cycles, required 10", i, acc[i] - acc[i-1]);
                end
            end
        end
    endtask

    task automatic test_random(input int sel, input int n, input int elat);
        logic [7:0] a, b, s, es; logic cin, sub, co, ov, ec, eo; int lat;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom);  b = 8'($urandom);  cin = 1'($urandom);  sub = 1'($urandom);
            model(a, b, cin, sub, es, ec, eo);
            do_op(sel, a, b, cin, sub, s, co, ov, lat);
            n_cmp++;
            if ({s, co, ov, lat} !== {es, ec, eo, elat}) begin
                n_err++;
                $display("FAIL random sel=%0d a=%h b=%h cin=%b sub=%b: got %h %b %b lat=%0d, required %h %b %b lat=%0d",
                         sel, a, b, cin, sub, s, co, ov, lat, es, ec, eo, elat);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d_valid = 1'b0;  d_ready = 1'b0;  d_cin = 1'b0;  d_sub = 1'b0;
        d_a = 8'h00;  d_b = 8'h00;  cur = 0;
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        test_random(1, 1000, 2);
        test_random(0, 200, 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
